// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-way intersection sequencer stepped by a 1 Hz enable pulse.
// Define TLC_PED_WALK_EN to build in the pedestrian request / WALK phase.
module traffic_light_fsm #(
  parameter int GREEN_SEC  = 10,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 1,
  parameter int WALK_SEC   = 5,
  parameter int CNT_W      = 5
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_ack,
  output logic [CNT_W-1:0] sec_left,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    WALK      = 3'd6
  } state_t;

  // Timer reload values: each state lasts its full duration because the
  // transition happens on the tick that finds the timer already at zero.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_SEC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_SEC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_SEC - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_SEC - 1);
  localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_ped_pending;
  logic             r_ped_ack;
  logic             r_walk;
  logic [2:0]       r_ns_light;
  logic [2:0]       r_ew_light;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_timer_next;
  logic             w_walk_go;
  logic             w_ped_pending_next;
  logic             w_ped_ack_next;

  function automatic logic [2:0] ns_lamp(input state_t s);
    case (s)
      NS_GREEN:  ns_lamp = LAMP_GRN;
      NS_YELLOW: ns_lamp = LAMP_YEL;
      default:   ns_lamp = LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input state_t s);
    case (s)
      EW_GREEN:  ew_lamp = LAMP_GRN;
      EW_YELLOW: ew_lamp = LAMP_YEL;
      default:   ew_lamp = LAMP_RED;
    endcase
  endfunction

  assign w_walk_go = r_ped_pending;

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    if (tick_1hz) begin
      if (r_timer == '0) begin
        case (r_state)
          NS_GREEN:  begin w_state_next = NS_YELLOW; w_timer_next = YELLOW_LD; end
          NS_YELLOW: begin w_state_next = ALL_RED_A; w_timer_next = ALLRED_LD; end
          ALL_RED_A: begin w_state_next = EW_GREEN;  w_timer_next = GREEN_LD;  end
          EW_GREEN:  begin w_state_next = EW_YELLOW; w_timer_next = YELLOW_LD; end
          EW_YELLOW: begin w_state_next = ALL_RED_B; w_timer_next = ALLRED_LD; end
          ALL_RED_B: begin
            if (w_walk_go) begin
              w_state_next = WALK;
              w_timer_next = WALK_LD;
            end else begin
              w_state_next = NS_GREEN;
              w_timer_next = GREEN_LD;
            end
          end
          default:   begin w_state_next = NS_GREEN;  w_timer_next = GREEN_LD;  end
        endcase
      end else begin
        w_timer_next = r_timer - TMR_ONE;
      end
    end
  end

`ifdef TLC_PED_WALK_EN
  logic w_enter_walk;
  assign w_enter_walk = (w_state_next == WALK) && (r_state != WALK);

  // A request arriving on the WALK-entry cycle is served by that walk.
  always_comb begin
    w_ped_pending_next = r_ped_pending;
    w_ped_ack_next     = 1'b0;
    if (w_enter_walk) begin
      w_ped_pending_next = 1'b0;
    end else if (ped_req && !r_ped_pending) begin
      w_ped_pending_next = 1'b1;
      w_ped_ack_next     = 1'b1;
    end
  end
`else
  logic w_ped_req_unused;
  assign w_ped_req_unused   = ped_req;
  assign w_ped_pending_next = 1'b0;
  assign w_ped_ack_next     = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state       <= ALL_RED_B;
      r_timer       <= ALLRED_LD;
      r_ped_pending <= 1'b0;
      r_ped_ack     <= 1'b0;
      r_walk        <= 1'b0;
      r_ns_light    <= LAMP_RED;
      r_ew_light    <= LAMP_RED;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_ped_pending <= w_ped_pending_next;
      r_ped_ack     <= w_ped_ack_next;
      r_walk        <= (w_state_next == WALK);
      r_ns_light    <= ns_lamp(w_state_next);
      r_ew_light    <= ew_lamp(w_state_next);
    end
  end

  assign ns_light = r_ns_light;
  assign ew_light = r_ew_light;
  assign walk     = r_walk;
  assign ped_ack  = r_ped_ack;
  assign sec_left = r_timer;
  assign phase    = r_state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: directed sequence with a cycle-level scoreboard for traffic_light_fsm.
// Expectations for the pedestrian path follow whether TLC_PED_WALK_EN is defined.
module tb_traffic_light_fsm;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [4:0] sec_left;
  logic [2:0] phase;

  int n_vec = 0;
  int n_err = 0;

`ifdef TLC_PED_WALK_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  traffic_light_fsm #(
    .GREEN_SEC (3),
    .YELLOW_SEC(2),
    .ALLRED_SEC(1),
    .WALK_SEC  (2),
    .CNT_W     (5)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .tick_1hz(tick_1hz),
    .ped_req (ped_req),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .walk    (walk),
    .ped_ack (ped_ack),
    .sec_left(sec_left),
    .phase   (phase)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: phase order and durations for the bench settings.
  typedef struct packed {
    logic [2:0] ph;
    logic [4:0] sec;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic       ack;
  } snap_t;

  int    dur [7] = '{3, 2, 1, 3, 2, 1, 2};
  int    m_phase = 5;
  int    m_timer = 0;
  bit    m_pend  = 1'b0;
  bit    m_ack   = 1'b0;
  snap_t sb_q[$];

  function automatic int follow(input int p, input bit pend);
    case (p)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 5;
      5: return pend ? 6 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit rq);
    int  np;
    bit  entering_walk;
    if (rst) begin
      m_phase = 5; m_timer = 0; m_pend = 1'b0; m_ack = 1'b0;
      return;
    end
    np = m_phase;
    entering_walk = 1'b0;
    if (tk) begin
      if (m_timer == 0) begin
        np = follow(m_phase, m_pend);
        m_timer = dur[np] - 1;
        entering_walk = (np == 6);
      end else begin
        m_timer = m_timer - 1;
      end
    end
    m_ack = 1'b0;
    if (PED_ON) begin
      if (entering_walk) m_pend = 1'b0;
      else if (rq && !m_pend) begin m_pend = 1'b1; m_ack = 1'b1; end
    end
    m_phase = np;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.ph  = 3'(m_phase);
    s.sec = 5'(m_timer);
    s.ns  = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    s.ew  = (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
    s.wk  = (m_phase == 6);
    s.ack = m_ack;
    return s;
  endfunction

  task automatic cyc(input bit rst, input bit tk, input bit rq);
    snap_t exp_s;
    snap_t obs_s;
    reset = rst; tick_1hz = tk; ped_req = rq;
    model_step(rst, tk, rq);
    sb_q.push_back(model_snap());
    @(posedge clk_in);
    #1;
    exp_s = sb_q.pop_front();
    obs_s = {phase, sec_left, ns_light, ew_light, walk, ped_ack};
    n_vec++;
    assert (obs_s === exp_s) else begin
      n_err++;
      $error("FAIL cycle_model obs ph=%0d sec=%0d ns=%b ew=%b walk=%b ack=%b exp ph=%0d sec=%0d ns=%b ew=%b walk=%b ack=%b",
             obs_s.ph, obs_s.sec, obs_s.ns, obs_s.ew, obs_s.wk, obs_s.ack,
             exp_s.ph, exp_s.sec, exp_s.ns, exp_s.ew, exp_s.wk, exp_s.ack);
    end
    n_vec++;
    assert (((ns_light == 3'b100) || (ew_light == 3'b100)) === 1'b1) else begin
      n_err++;
      $error("FAIL both_nonred ns=%b ew=%b required one red", ns_light, ew_light);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_tick(input bit rq);
    cyc(1'b0, 1'b1, rq);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, rq);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) do_tick(1'b0);
  endtask

  int tbl_ph [11] = '{0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5};
  int tbl_sec[11] = '{1, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0};

  initial begin
    // Reset
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("rst_phase", 32'(phase), 5);
    chk("rst_ns", 32'(ns_light), 4);
    chk("rst_ew", 32'(ew_light), 4);
    chk("rst_sec", 32'(sec_left), 0);
    chk("rst_walk", 32'(walk), 0);
    chk("rst_ack", 32'(ped_ack), 0);

    // Full cycle without requests
    do_tick(1'b0);
    chk("first_ns_green_phase", 32'(phase), 0);
    chk("first_ns_green_sec", 32'(sec_left), 2);
    for (int i = 0; i < 11; i++) begin
      do_tick(1'b0);
      chk($sformatf("cycle_phase_%0d", i), 32'(phase), 32'(tbl_ph[i]));
      chk($sformatf("cycle_sec_%0d", i), 32'(sec_left), 32'(tbl_sec[i]));
    end

    // Pedestrian request during EW_GREEN, repeat, then request on WALK entry
    do_tick(1'b0);
    ticks(6);
    chk("ew_green_phase", 32'(phase), 3);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ped_ack_first", 32'(ped_ack), 32'(PED_ON));
    cyc(1'b0, 1'b0, 1'b1);
    chk("ped_ack_repeat", 32'(ped_ack), 0);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(5);
    chk("all_red_b_phase", 32'(phase), 5);
    cyc(1'b0, 1'b1, 1'b1);
    chk("walk_entry_phase", 32'(phase), PED_ON ? 6 : 0);
    chk("walk_entry_lamp", 32'(walk), 32'(PED_ON));
    chk("walk_entry_ack", 32'(ped_ack), 0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0);
`ifdef TLC_PED_WALK_EN
    do_tick(1'b0);
    chk("walk_hold_phase", 32'(phase), 6);
    chk("walk_hold_lamp", 32'(walk), 1);
    do_tick(1'b0);
    chk("walk_exit_walk", 32'(walk), 0);
`endif
    chk("post_walk_phase", 32'(phase), 0);
    chk("post_walk_sec", 32'(sec_left), 2);
    ticks(12);
    chk("absorbed_req_phase", 32'(phase), 0);

    // Stall then burst tick
    for (int k = 0; k < 100; k++) cyc(1'b0, 1'b0, 1'b0);
    chk("stall_phase", 32'(phase), 0);
    chk("stall_sec", 32'(sec_left), 2);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("burst_phase", 32'(phase), 1);
    chk("burst_sec", 32'(sec_left), 1);
    cyc(1'b0, 1'b0, 1'b0);

    // Mid-operation reset with a pending request and a coincident tick
    ticks(6);
    chk("ew_yellow_phase", 32'(phase), 4);
    cyc(1'b0, 1'b0, 1'b1);
    chk("pre_reset_ack", 32'(ped_ack), 32'(PED_ON));
    cyc(1'b1, 1'b1, 1'b0);
    chk("midrst_phase", 32'(phase), 5);
    chk("midrst_sec", 32'(sec_left), 0);
    chk("midrst_ns", 32'(ns_light), 4);
    chk("midrst_ew", 32'(ew_light), 4);
    cyc(1'b0, 1'b0, 1'b0);
    do_tick(1'b0);
    chk("midrst_discard_phase", 32'(phase), 0);
    chk("midrst_discard_walk", 32'(walk), 0);

`ifndef TLC_PED_WALK_EN
    // Request held through a whole cycle has no effect without the walk feature
    for (int i = 0; i < 48; i++) begin
      cyc(1'b0, (i % 4) == 0, 1'b1);
      chk("held_req_walk", 32'(walk), 0);
      chk("held_req_ack", 32'(ped_ack), 0);
      chk("held_req_no_walk_phase", 32'(phase == 3'd6), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=sequence_complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

- Sequences a two-way intersection (north-south / east-west) through green, yellow and all-red phases.
- Timing is in whole seconds, advanced by a 1 Hz single-cycle enable pulse from the upstream clock-divider stage.
- Sits directly downstream of that divider and drives the lamp outputs and the pedestrian WALK indicator.
- Runs entirely in the `clk_in` domain; no derived clocks.

## Interface
- `GREEN_SEC`, 10: green duration per direction, in ticks.
- `YELLOW_SEC`, 3: yellow duration, in ticks.
- `ALLRED_SEC`, 1: all-red clearance duration, in ticks.
- `WALK_SEC`, 5: pedestrian walk duration, in ticks.
- `CNT_W`, 5: timer width. Every duration must be in 1..2^CNT_W.

- `clk_in` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `tick_1hz` input 1: single-cycle enable pulse, once per second, from upstream.
- `ped_req` input 1: pedestrian request, level or pulse.
- `ns_light` output 3: {red, yellow, green}, one-hot.
- `ew_light` output 3: {red, yellow, green}, one-hot.
- `walk` output 1: pedestrian WALK lamp.
- `ped_ack` output 1: one-cycle pulse when a request is latched.
- `sec_left` output CNT_W: current timer value, i.e. ticks remaining minus one.
- `phase` output 3: encoded state, for debug.

## Operation
- States and `phase` encodings:
  - `NS_GREEN`=0, `NS_YELLOW`=1, `ALL_RED_A`=2, `EW_GREEN`=3, `EW_YELLOW`=4, `ALL_RED_B`=5, `WALK`=6.
- Fixed cycle: `NS_GREEN` → `NS_YELLOW` → `ALL_RED_A` → `EW_GREEN` → `EW_YELLOW` → `ALL_RED_B` → `NS_GREEN`.
- `ALL_RED_B` exits to `WALK` instead of `NS_GREEN` when `ped_pending`=1.
- `WALK` → `NS_GREEN`.
- Timer behaviour:
  - Loaded with (duration−1) on state entry.
  - Decrements on each `tick_1hz`.
  - `tick_1hz` with timer==0 causes the transition and reloads the timer for the next state.
  - Each state therefore lasts exactly its duration in ticks.
- Cycles without `tick_1hz` hold state and timer unchanged.
- Lamp decode from state:
  - NS green/yellow states: `ew_light`=red.
  - EW green/yellow states: `ns_light`=red.
  - `ALL_RED_*` and `WALK`: both directions red.
  - `walk`=1 only in `WALK`.
- Both directions are never non-red in the same cycle, in any state.
- Pedestrian request handling:
  - `ped_req`=1 while `ped_pending`=0 sets `ped_pending` and pulses `ped_ack` on the next cycle.
  - Further requests while pending produce no new ack.
  - `ped_pending` clears on entry to `WALK`.
  - A `ped_req` in the same cycle as `WALK` entry is absorbed by that walk: pending stays 0, no ack.
  - `ped_req` during `WALK` is latched normally and serves the next cycle.
- Reset values:
  - state=`ALL_RED_B`, timer=`ALLRED_SEC`−1, `ped_pending`=0.
  - `ns_light`=`ew_light`=3'b100, `walk`=0, `ped_ack`=0.
  - `sec_left`=`ALLRED_SEC`−1, `phase`=5.
- `reset` mid-operation returns to the reset values at the next edge and discards any pending request.
- `tick_1hz` coincident with `reset` is ignored.

## Timing
- State, timer and `ped_pending` are registered.
- Lamps, `walk` and `phase` are decoded from registered state, so they change on the edge after the terminal-tick cycle (1-cycle latency).
- `sec_left` reflects the registered timer with no extra delay.
- `ped_ack` is registered: high exactly one cycle, the cycle after `ped_req` is first sampled.
- `tick_1hz` must be a single-cycle pulse. If held high for k cycles, it counts as k ticks; no deglitching is performed.
- No handshake with upstream: `tick_1hz` is consumed every cycle it is high.

## Configuration
- `TLC_PED_WALK_EN` defined:
  - Pedestrian logic present: `ped_pending`, `ped_ack`, `WALK` state.
- `TLC_PED_WALK_EN` undefined:
  - `ped_req` ignored; `walk` and `ped_ack` tied 0.
  - `WALK` unreachable; `ALL_RED_B` always exits to `NS_GREEN`.
  - Ports remain present.

## Test plan
Bench settings: `GREEN_SEC`=3, `YELLOW_SEC`=2, `ALLRED_SEC`=1, `WALK_SEC`=2, `tick_1hz` every 4 cycles unless stated.

- Reset check: `reset` high 2 cycles → `phase`=5, both lights 3'b100, `sec_left`=0, `walk`=0, `ped_ack`=0.
- Full cycle, no request: 1 tick → `NS_GREEN`; then 3/2/1/3/2/1 ticks visit phases 0,1,2,3,4,5, with `sec_left` counting 2,1,0 in green; no cycle has both lights non-red.
- Pedestrian request (macro on): `ped_req` pulse during `EW_GREEN` → `ped_ack` 1 cycle later; after `ALL_RED_B`, `phase`=6, `walk`=1 for 2 ticks, then `NS_GREEN` with `walk`=0.
- Repeated and simultaneous requests: second `ped_req` while pending → no second `ack`; `ped_req` in the `WALK`-entry cycle → no `ack`, and the next `ALL_RED_B` goes to `NS_GREEN`.
- Stall and burst ticks: no `tick_1hz` for 100 cycles → state and `sec_left` frozen; `tick_1hz` held 3 cycles in `NS_GREEN` with `sec_left`=2 → `NS_YELLOW` with `sec_left`=1.
- Mid-operation reset and macro off: `reset` during `EW_YELLOW` with pending request → reset values, then cycle runs without `WALK`; with macro undefined, `ped_req` held high for a full cycle → `walk`/`ped_ack` stay 0 and `phase` never equals 6.
